oversample_multi: RTL

- Generalised oversampling decimator; successor to the fixed 16x and 256x oversamplers.
- Accumulates 2^k ADC samples per channel and emits one full-scale-normalised averaged sample per frame; k is selectable at runtime.
- Input is interleaved multi-channel: one sample per eoc pulse, tagged with a channel index.
- Sits between the XADC DRP read (sample_reg, eoc) and the FFT / PWM consumers, so one instance feeds several guitar inputs at any decimation ratio.

---
 rtl/oversample_multi.sv | 103 ++++++++++
 1 files changed

// File: rtl/oversample_multi.sv
// Multi-channel oversampling decimator: accumulates 2^k interleaved samples per
// channel and emits one full-scale-normalised average per completed frame.
module oversample_multi #(
    parameter int IN_W     = 12,
    parameter int CHANNELS = 2,
    parameter int MAX_LOG2 = 8,
    parameter int OUT_W    = 16,
    parameter int CH_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   sample,
    input  logic              eoc,
    input  logic [CH_W-1:0]   chan,
    input  logic [3:0]        log2_ratio,
    output logic [OUT_W-1:0]  oversample,
    output logic [CH_W-1:0]   out_chan,
    output logic              done
);
    localparam int AW = IN_W + MAX_LOG2;
    localparam int CW = MAX_LOG2 + 1;
    localparam logic [3:0]    MAX_K = 4'(MAX_LOG2);
    localparam logic [CH_W:0] NCH   = (CH_W + 1)'(CHANNELS);

    logic [AW-1:0]    r_acc [CHANNELS];
    logic [CW-1:0]    r_cnt [CHANNELS];
    logic [3:0]       r_ratio_q;
    logic [OUT_W-1:0] r_oversample;
    logic [CH_W-1:0]  r_out_chan;
    logic             r_done;

    logic [3:0]    w_k_eff;
    logic          w_change;
    logic          w_in_range;
    logic          w_accept;
    logic          w_complete;
    logic [AW-1:0] w_acc_cur;
    logic [CW-1:0] w_cnt_cur;
    logic [AW-1:0] w_acc_sum;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_target;
    logic [3:0]    w_shift_amt;

    assign w_k_eff     = (log2_ratio > MAX_K) ? MAX_K : log2_ratio;
    assign w_change    = (w_k_eff != r_ratio_q);
    assign w_in_range  = ({1'b0, chan} < NCH);
    assign w_accept    = eoc && w_in_range && !w_change;
    assign w_acc_sum   = w_acc_cur + AW'(sample);
    assign w_cnt_inc   = w_cnt_cur + CW'(1);
    assign w_target    = CW'(1) << r_ratio_q;
    assign w_complete  = w_accept && (w_cnt_inc == w_target);
    // Left-justify the sum so every k maps full-scale input onto full-scale output.
    assign w_shift_amt = MAX_K - r_ratio_q;

    always_comb begin
        w_acc_cur = '0;
        w_cnt_cur = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (chan == CH_W'(c)) begin
                w_acc_cur = r_acc[c];
                w_cnt_cur = r_cnt[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
                r_cnt[c] <= '0;
            end
            r_ratio_q    <= '0;
            r_oversample <= '0;
            r_out_chan   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_ratio_q <= w_k_eff;
            r_done    <= w_complete;
            if (w_change) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    r_acc[c] <= '0;
                    r_cnt[c] <= '0;
                end
            end else if (w_accept) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (chan == CH_W'(c)) begin
                        r_acc[c] <= w_complete ? '0 : w_acc_sum;
                        r_cnt[c] <= w_complete ? '0 : w_cnt_inc;
                    end
                end
            end
            if (w_complete) begin
                r_out_chan   <= chan;
                r_oversample <= OUT_W'(AW'(w_acc_sum << w_shift_amt) >> (AW - OUT_W));
            end
        end
    end

    assign oversample = r_oversample;
    assign out_chan   = r_out_chan;
    assign done       = r_done;

endmodule
